// File: rtl/mem_access_unit.sv
// Data-memory responder behind AR: accepts a read or write request in IDLE,
// runs it through a fixed-length ACCESS phase and reports completion with Done.
module mem_access_unit #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] AR_in,
  input  logic              Mem_rd,
  input  logic              Mem_wr,
  input  logic [DATA_W-1:0] Wr_data,
  output logic [DATA_W-1:0] Rd_data,
  output logic              Busy,
  output logic              Done,
  output logic              Addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(WAIT_STATES);
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_COMPLETE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_op_q, wr_op_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                addr_err_q, addr_err_d;
  logic                mem_we_s;
  logic [IDX_W-1:0]    idx_s;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  // Full-width compare so addresses beyond DEPTH never alias onto real words.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_LIM);
  endfunction

  assign idx_s = addr_q[IDX_W-1:0];

  // Next-state, request capture and commit decisions.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_op_d    = wr_op_q;
    err_d      = err_q;
    rd_data_d  = rd_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    addr_err_d = 1'b0;
    mem_we_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Mem_rd | Mem_wr) begin
          addr_d  = AR_in;
          wdata_d = Wr_data;
          wr_op_d = Mem_wr & ~Mem_rd;
          err_d   = (Mem_rd & Mem_wr) | ~addr_ok(AR_in);
          cnt_d   = CNT_LOAD;
          state_d = ST_ACCESS;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      ST_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d    = ST_COMPLETE;
          done_d     = 1'b1;
          addr_err_d = err_q;
          // A flagged request still takes the full latency but never touches the array.
          if (err_q) begin
            mem_we_s = 1'b0;
          end else if (wr_op_q) begin
            mem_we_s = 1'b1;
          end else begin
            rd_data_d = mem_q[idx_s];
          end
        end
      end
      ST_COMPLETE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_op_q    <= 1'b0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_op_q    <= wr_op_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Word array: deliberately unreset; a reset during ACCESS leaves state IDLE so no write fires.
  always_ff @(posedge Clock) begin
    if (mem_we_s) begin
      mem_q[idx_s] <= wdata_q;
    end
  end

  assign Rd_data  = rd_data_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Addr_err = addr_err_q;

endmodule
